// File: rtl/colnorm_sort_unit.sv
// Column-norm sorter: computes squared column norms of H, orders columns by norm, emits permuted H.
// Latency 2N+1 cycles from accept to out_valid; holds outputs and stalls input until out_ready.
module colnorm_sort_unit #(
  parameter int N  = 8,
  parameter int WL = 16,
  localparam int IDXW = $clog2(N),
  localparam int NW   = 2*WL + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*N*WL-1:0]     H_i,
  input  logic [N*WL-1:0]       Y_i,
  input  logic                  descend_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*N*WL-1:0]     H_o,
  output logic [N*WL-1:0]       Y_o,
  output logic [N*IDXW-1:0]     colorder_o,
  output logic [N*NW-1:0]       colnorm_o,
  output logic                  busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] NORM = 3'd1;
  localparam logic [2:0] SORT = 3'd2;
  localparam logic [2:0] PERM = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]            state;
  logic [N*N*WL-1:0]     h_reg;
  logic [N*WL-1:0]       y_reg;
  logic                  desc_reg;
  logic [IDXW-1:0]       cnt;
  logic [N-1:0]          taken;
  logic [NW-1:0]         norm [N];
  logic [IDXW-1:0]       order [N];

  logic [NW-1:0]         col_sum;
  logic signed [WL-1:0]  elem;
  logic signed [2*WL-1:0] prod;
  logic [IDXW-1:0]       best_idx;
  logic [NW-1:0]         best_norm;
  logic                  found;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Squared norm of column cnt; squares are non-negative so zero-extension is exact.
  always_comb begin
    col_sum = '0;
    elem    = '0;
    prod    = '0;
    for (int r = 0; r < N; r++) begin
      elem    = h_reg[(int'(cnt)*N + r)*WL +: WL];
      prod    = (2*WL)'(elem) * (2*WL)'(elem);
      col_sum = col_sum + {{(NW-2*WL){1'b0}}, prod};
    end
  end

  // Strict compare keeps the lowest index among equal norms in both directions.
  always_comb begin
    best_idx  = '0;
    best_norm = '0;
    found     = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (!taken[c]) begin
        if (!found || (desc_reg ? (norm[c] > best_norm) : (norm[c] < best_norm))) begin
          best_idx  = IDXW'(c);
          best_norm = norm[c];
          found     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      h_reg     <= '0;
      y_reg     <= '0;
      desc_reg  <= 1'b0;
      cnt       <= '0;
      taken     <= '0;
      out_valid <= 1'b0;
      H_o       <= '0;
      Y_o       <= '0;
      colnorm_o <= '0;
      for (int k = 0; k < N; k++) begin
        norm[k]                      <= '0;
        order[k]                     <= '0;
        colorder_o[k*IDXW +: IDXW]   <= IDXW'(k);
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            h_reg    <= H_i;
            y_reg    <= Y_i;
            desc_reg <= descend_i;
            taken    <= '0;
            cnt      <= '0;
            state    <= NORM;
          end
        end
        NORM: begin
          norm[cnt] <= col_sum;
          cnt       <= cnt + 1'b1;
          if (cnt == IDXW'(N-1)) state <= SORT;
        end
        SORT: begin
          order[cnt]      <= best_idx;
          taken[best_idx] <= 1'b1;
          cnt             <= cnt + 1'b1;
          if (cnt == IDXW'(N-1)) state <= PERM;
        end
        PERM: begin
          for (int k = 0; k < N; k++) begin
            H_o[k*N*WL +: N*WL]        <= h_reg[int'(order[k])*N*WL +: N*WL];
            colnorm_o[k*NW +: NW]      <= norm[order[k]];
            colorder_o[k*IDXW +: IDXW] <= order[k];
          end
          Y_o       <= y_reg;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_colnorm_sort_unit.sv
// Bench for colnorm_sort_unit (N=8, WL=16): directed matrices, scoreboard of expected outputs.
module tb_colnorm_sort_unit;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] H_i;
  logic [127:0]  Y_i;
  logic          descend_i;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] H_o;
  logic [127:0]  Y_o;
  logic [23:0]   colorder_o;
  logic [279:0]  colnorm_o;
  logic          busy;

  typedef struct packed {
    logic [23:0]   order;
    logic [279:0]  norms;
    logic [1023:0] h;
    logic [127:0]  y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  colnorm_sort_unit #(.N(8), .WL(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .H_i(H_i), .Y_i(Y_i), .descend_i(descend_i), .out_valid(out_valid),
    .out_ready(out_ready), .H_o(H_o), .Y_o(Y_o), .colorder_o(colorder_o),
    .colnorm_o(colnorm_o), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %h want %h", tag, obs, expv);
  endtask

  // Reference: exact norms, then a stable insertion sort on the column indices.
  function automatic exp_t model(input logic [1023:0] h, input logic [127:0] y, input logic d);
    exp_t   e;
    longint nrm [8];
    int     idx [8];
    longint v;
    int     t;
    int     j;
    for (int c = 0; c < 8; c++) begin
      nrm[c] = 0;
      for (int r = 0; r < 8; r++) begin
        v = longint'($signed(h[(c*8+r)*16 +: 16]));
        nrm[c] += v * v;
      end
      idx[c] = c;
    end
    for (int i = 1; i < 8; i++) begin
      j = i;
      while (j > 0 && (d ? (nrm[idx[j]] > nrm[idx[j-1]]) : (nrm[idx[j]] < nrm[idx[j-1]]))) begin
        t = idx[j]; idx[j] = idx[j-1]; idx[j-1] = t;
        j--;
      end
    end
    for (int k = 0; k < 8; k++) begin
      e.order[k*3 +: 3]   = 3'(idx[k]);
      e.norms[k*35 +: 35] = 35'(nrm[idx[k]]);
      e.h[k*128 +: 128]   = h[idx[k]*128 +: 128];
    end
    e.y = y;
    return e;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_colorder"}, colorder_o, 24'hFAC688);
    chk({tag, "_colnorm_lo"}, colnorm_o[255:0], 0);
    chk({tag, "_colnorm_hi"}, colnorm_o[279:256], 0);
    for (int s = 0; s < 4; s++) chk({tag, "_H_o"}, H_o[s*256 +: 256], 0);
    chk({tag, "_Y_o"}, Y_o, 0);
  endtask

  task automatic run_tx(input logic [1023:0] h, input logic [127:0] y, input logic d, input int bp);
    exp_t          e;
    int            lat;
    int            w;
    logic [1023:0] sh;
    logic [23:0]   so;
    logic [279:0]  sn;
    sb.push_back(model(h, y, d));
    @(negedge clk);
    H_i = h; Y_i = y; descend_i = d; in_valid = 1'b1; out_ready = (bp == 0);
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("in_ready_after_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("latency", lat, 17);
    e = sb.pop_front();
    chk("colorder", colorder_o, e.order);
    for (int k = 0; k < 8; k++) chk("colnorm", colnorm_o[k*35 +: 35], e.norms[k*35 +: 35]);
    for (int k = 0; k < 8; k++) chk("H_o_col", H_o[k*128 +: 128], e.h[k*128 +: 128]);
    chk("Y_o", Y_o, e.y);
    if (bp > 0) begin
      sh = H_o; so = colorder_o; sn = colnorm_o;
      in_valid = 1'b1; H_i = ~h; descend_i = ~d;
      repeat (bp) begin
        @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_colorder", colorder_o, so);
        chk("hold_colnorm", colnorm_o[255:0], sn[255:0]);
        chk("hold_H_col0", H_o[255:0], sh[255:0]);
        chk("hold_H_col7", H_o[1023:768], sh[1023:768]);
      end
      in_valid = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    chk("out_valid_clear", out_valid, 0);
    chk("in_ready_next", in_ready, 1);
  endtask

  initial begin
    logic [1023:0] h;
    logic [127:0]  y;
    logic [31:0]   rv;
    int            seen;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; descend_i = 1'b0; H_i = '0; Y_i = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b1;

    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) h[(c*8+r)*16 +: 16] = 16'(c + 1);
    for (int r = 0; r < 8; r++) y[r*16 +: 16] = 16'(16'h1000 + r * 3);

    run_tx(h, y, 1'b0, 0);
    chk("asc_identity", colorder_o, 24'hFAC688);
    chk("asc_norm0", colnorm_o[34:0], 35'd8);
    chk("asc_norm7", colnorm_o[279:245], 35'd512);
    chk("asc_H_passthru", H_o[255:0], h[255:0]);

    run_tx(h, y, 1'b1, 10);
    chk("desc_order", colorder_o, 24'h053977);
    chk("desc_H_col0", H_o[127:0], h[1023:896]);

    h = '0;
    for (int c = 0; c < 8; c++) h[(c*8)*16 +: 16] = 16'd10;
    h[(2*8)*16 +: 16] = 16'd5; h[(2*8+1)*16 +: 16] = 16'd5;
    h[(5*8)*16 +: 16] = 16'd5; h[(5*8+1)*16 +: 16] = 16'd5;
    run_tx(h, y, 1'b0, 0);
    chk("tie_asc_f0", colorder_o[2:0], 3'd2);
    chk("tie_asc_f1", colorder_o[5:3], 3'd5);
    chk("tie_asc_norm0", colnorm_o[34:0], 35'd50);

    for (int c = 0; c < 8; c++) h[(c*8)*16 +: 16] = 16'd1;
    h[(2*8)*16 +: 16] = 16'd5; h[(5*8)*16 +: 16] = 16'd5;
    run_tx(h, y, 1'b1, 0);
    chk("tie_desc_f0", colorder_o[2:0], 3'd2);
    chk("tie_desc_f1", colorder_o[5:3], 3'd5);

    for (int i = 0; i < 64; i++) h[i*16 +: 16] = 16'h8000;
    run_tx(h, y, 1'b1, 0);
    chk("extreme_order", colorder_o, 24'hFAC688);
    for (int k = 0; k < 8; k++) chk("extreme_norm", colnorm_o[k*35 +: 35], 35'h2_0000_0000);

    run_tx('0, '0, 1'b1, 0);
    chk("zero_order", colorder_o, 24'hFAC688);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) begin
        rv = $urandom;
        h[i*16 +: 16] = (t == 2) ? 16'($signed(int'(rv[2:0])) - 3) : rv[15:0];
      end
      for (int r = 0; r < 8; r++) begin rv = $urandom; y[r*16 +: 16] = rv[15:0]; end
      run_tx(h, y, t[0], (t == 1) ? 3 : 0);
    end

    // Abort a transaction mid-SORT; it must leave no trace.
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) h[(c*8+r)*16 +: 16] = 16'(8 - c);
    @(negedge clk);
    H_i = h; Y_i = y; descend_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("mid_sort_reset");
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    chk("no_out_after_reset", seen, 0);

    run_tx(h, y, 1'b0, 0);
    chk("post_reset_order", colorder_o, 24'h053977);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
